// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-stage RAW/WAW hazard controller for the general and
// float register files. Keeps one saturating pending-write counter per
// register, blocks issue on hazards and retires pending writes from the
// writeback ports.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   issue_valid / issue_ready  instruction offered / no hazard (combinational)
//   issue_src_*                three source operands: number, read enable, file
//   issue_out_*                decoder destination: general, float, number
//   wb_valid/wb_float/wb_num   NUM_WB writeback ports
//   flush                      discard all pending state
//   busy                       any counter nonzero (registered)
//   stall_count                cycles with issue_valid && !issue_ready
//   underflow_err              sticky: a writeback hit a zero counter
module reg_scoreboard #(
  parameter int unsigned NUM_WB    = 2,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WAW_STALL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [2:0][4:0]        issue_src_num,
  input  logic [2:0]             issue_src_used,
  input  logic [2:0]             issue_src_float,
  input  logic                   issue_out_general,
  input  logic                   issue_out_float,
  input  logic [4:0]             issue_out_reg_num,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB-1:0]      wb_float,
  input  logic [NUM_WB-1:0][4:0] wb_num,
  input  logic                   flush,
  output logic                   busy,
  output logic [31:0]            stall_count,
  output logic                   underflow_err
);

  // Counter index is {float, reg_num}: 0..31 general, 32..63 float.
  localparam int unsigned NREG    = 64;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned HIT_W   = $clog2(NUM_WB + 1);
  localparam int unsigned SUM_W   = CNT_W + HIT_W + 2;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             busy_d;
  logic             underflow_d;
  logic [31:0]      stall_count_d;

  logic             dest_valid;
  logic [IDX_W-1:0] dest_idx;
  logic [CNT_W-1:0] dest_cnt;
  logic             raw_hit;
  logic             waw_hit;
  logic             inc_en;
  logic [HIT_W-1:0] hits;
  logic [SUM_W-1:0] sum;

  // Hazard detection from registered counters only (no writeback bypass).
  // Both destination flags set is treated as general; g0 is never a destination.
  always_comb begin
    dest_idx   = {~issue_out_general & issue_out_float, issue_out_reg_num};
    dest_valid = issue_out_general ? (issue_out_reg_num != 5'd0) : issue_out_float;
    dest_cnt   = cnt_q[dest_idx];
    raw_hit    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (issue_src_used[i] && (cnt_q[{issue_src_float[i], issue_src_num[i]}] != '0)) begin
        raw_hit = 1'b1;
      end
    end
    if (WAW_STALL) begin
      waw_hit = dest_valid && (dest_cnt != '0);
    end else begin
      waw_hit = dest_valid && (dest_cnt == CNT_W'(CNT_MAX));
    end
    issue_ready = !raw_hit && !waw_hit;
    inc_en      = issue_valid && issue_ready && dest_valid;
  end

  // Per-register net update: +accept - writeback hits, clamped to [0, max].
  // Index 0 (g0) is skipped so it stays zero and ignores writebacks.
  always_comb begin
    cnt_d         = cnt_q;
    underflow_d   = underflow_err;
    busy_d        = 1'b0;
    hits          = '0;
    sum           = '0;
    stall_count_d = stall_count + 32'(issue_valid && !issue_ready);
    cnt_d[0]      = '0;
    for (int r = 1; r < NREG; r++) begin
      hits = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && ({wb_float[p], wb_num[p]} == IDX_W'(r))) begin
          hits = hits + HIT_W'(1);
        end
      end
      sum = SUM_W'(cnt_q[r]) + SUM_W'(inc_en && (dest_idx == IDX_W'(r))) - SUM_W'(hits);
      if (sum[SUM_W-1]) begin
        cnt_d[r]    = '0;
        underflow_d = 1'b1;
      end else if (sum > SUM_W'(CNT_MAX)) begin
        cnt_d[r] = CNT_W'(CNT_MAX);
      end else begin
        cnt_d[r] = CNT_W'(sum);
      end
    end
    // Flush overrides accept and writeback in the same cycle.
    if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
      underflow_d = underflow_err;
    end
    for (int r = 0; r < NREG; r++) begin
      busy_d = busy_d | (|cnt_d[r]);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      busy          <= 1'b0;
      stall_count   <= '0;
      underflow_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy          <= busy_d;
      stall_count   <= stall_count_d;
      underflow_err <= underflow_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard. Two instances (WAW_STALL=1 and WAW_STALL=0)
// share one stimulus stream; a pending-count model of each is checked on
// every falling edge, with directed scenarios followed by random traffic.
module tb_reg_scoreboard;

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic [2:0][4:0] issue_src_num;
  logic [2:0]      issue_src_used;
  logic [2:0]      issue_src_float;
  logic            issue_out_general;
  logic            issue_out_float;
  logic [4:0]      issue_out_reg_num;
  logic [1:0]      wb_valid;
  logic [1:0]      wb_float;
  logic [1:0][4:0] wb_num;
  logic            flush;

  // Index 1: WAW_STALL=1 instance, index 0: WAW_STALL=0 instance.
  logic [1:0]       rdy;
  logic [1:0]       bsy;
  logic [1:0]       ufe;
  logic [1:0][31:0] stc;

  reg_scoreboard #(.NUM_WB(2), .CNT_W(2), .WAW_STALL(1'b1)) u_waw1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(rdy[1]),
    .issue_src_num(issue_src_num), .issue_src_used(issue_src_used),
    .issue_src_float(issue_src_float), .issue_out_general(issue_out_general),
    .issue_out_float(issue_out_float), .issue_out_reg_num(issue_out_reg_num),
    .wb_valid(wb_valid), .wb_float(wb_float), .wb_num(wb_num), .flush(flush),
    .busy(bsy[1]), .stall_count(stc[1]), .underflow_err(ufe[1])
  );

  reg_scoreboard #(.NUM_WB(2), .CNT_W(2), .WAW_STALL(1'b0)) u_waw0 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(rdy[0]),
    .issue_src_num(issue_src_num), .issue_src_used(issue_src_used),
    .issue_src_float(issue_src_float), .issue_out_general(issue_out_general),
    .issue_out_float(issue_out_float), .issue_out_reg_num(issue_out_reg_num),
    .wb_valid(wb_valid), .wb_float(wb_float), .wb_num(wb_num), .flush(flush),
    .busy(bsy[0]), .stall_count(stc[0]), .underflow_err(ufe[0])
  );

  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  int          m_cnt [2][2][32];   // [instance][file][reg] pending writes
  logic [31:0] m_stall [2];
  bit          m_uf [2];
  bit          m_busy [2];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Issue allowed iff no used source has a pending write and the destination
  // is free (WAW_STALL=1) or below the counter maximum of 3 (WAW_STALL=0).
  function automatic bit m_ready(input int w);
    bit r;
    int c;
    r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (issue_src_used[i] && !(issue_src_float[i] == 1'b0 && issue_src_num[i] == 5'd0) &&
          m_cnt[w][issue_src_float[i]][issue_src_num[i]] != 0) r = 1'b0;
    end
    c = -1;
    if (issue_out_general) begin
      if (issue_out_reg_num != 5'd0) c = m_cnt[w][0][issue_out_reg_num];
    end else if (issue_out_float) begin
      c = m_cnt[w][1][issue_out_reg_num];
    end
    if (c >= 0) begin
      if (w == 1 && c != 0) r = 1'b0;
      if (w == 0 && c >= 3) r = 1'b0;
    end
    return r;
  endfunction

  task automatic m_reset();
    for (int w = 0; w < 2; w++) begin
      for (int f = 0; f < 2; f++)
        for (int n = 0; n < 32; n++) m_cnt[w][f][n] = 0;
      m_stall[w] = '0;
      m_uf[w]    = 1'b0;
      m_busy[w]  = 1'b0;
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic m_step();
    int d [2][32];
    int v;
    bit r;
    for (int w = 0; w < 2; w++) begin
      r = m_ready(w);
      if (issue_valid && !r) m_stall[w] = m_stall[w] + 32'd1;
      for (int f = 0; f < 2; f++)
        for (int n = 0; n < 32; n++) d[f][n] = 0;
      if (issue_valid && r) begin
        if (issue_out_general) begin
          if (issue_out_reg_num != 5'd0) d[0][issue_out_reg_num] += 1;
        end else if (issue_out_float) begin
          d[1][issue_out_reg_num] += 1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && !(wb_float[p] == 1'b0 && wb_num[p] == 5'd0))
          d[wb_float[p]][wb_num[p]] -= 1;
      end
      for (int f = 0; f < 2; f++) begin
        for (int n = 0; n < 32; n++) begin
          if (flush) begin
            v = 0;
          end else begin
            v = m_cnt[w][f][n] + d[f][n];
            if (v < 0) begin
              v = 0;
              m_uf[w] = 1'b1;
            end else if (v > 3) begin
              v = 3;
            end
          end
          m_cnt[w][f][n] = v;
        end
      end
      m_busy[w] = 1'b0;
      for (int f = 0; f < 2; f++)
        for (int n = 0; n < 32; n++)
          if (m_cnt[w][f][n] != 0) m_busy[w] = 1'b1;
    end
  endtask

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_reset();
      for (int w = 0; w < 2; w++) begin
        chk("rst_busy", w, 32'(bsy[w]), 32'(m_busy[w]));
        chk("rst_stall", w, stc[w], m_stall[w]);
        chk("rst_uf", w, 32'(ufe[w]), 32'(m_uf[w]));
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        chk("ready", w, 32'(rdy[w]), 32'(m_ready(w)));
        chk("busy", w, 32'(bsy[w]), 32'(m_busy[w]));
        chk("stall_count", w, stc[w], m_stall[w]);
        chk("underflow", w, 32'(ufe[w]), 32'(m_uf[w]));
      end
      m_step();
    end
  end

  task automatic idle();
    issue_valid       = 1'b0;
    issue_src_num     = '0;
    issue_src_used    = '0;
    issue_src_float   = '0;
    issue_out_general = 1'b0;
    issue_out_float   = 1'b0;
    issue_out_reg_num = '0;
    wb_valid          = '0;
    wb_float          = '0;
    wb_num            = '0;
    flush             = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dest(input bit gen, input bit flt, input logic [4:0] n);
    issue_valid       = 1'b1;
    issue_out_general = gen;
    issue_out_float   = flt;
    issue_out_reg_num = n;
  endtask

  task automatic src(input int i, input bit f, input logic [4:0] n);
    issue_valid        = 1'b1;
    issue_src_used[i]  = 1'b1;
    issue_src_float[i] = f;
    issue_src_num[i]   = n;
  endtask

  task automatic wb(input int p, input bit f, input logic [4:0] n);
    wb_valid[p] = 1'b1;
    wb_float[p] = f;
    wb_num[p]   = n;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    m_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("reset_ready", 1, 32'(rdy[1]), 32'd1);
    chk("reset_busy", 1, 32'(bsy[1]), 32'd0);
    chk("reset_stall", 1, stc[1], 32'd0);

    // Destination g21 then RAW on g21.
    dest(1'b1, 1'b0, 5'd21);
    settle();
    chk("g21_issue_ready", 1, 32'(rdy[1]), 32'd1);
    cyc();
    idle();
    settle();
    chk("g21_busy", 1, 32'(bsy[1]), 32'd1);
    chk("g21_model", 1, 32'(m_cnt[1][0][21]), 32'd1);
    src(0, 1'b0, 5'd21);
    settle();
    chk("g21_raw", 1, 32'(rdy[1]), 32'd0);
    cyc();
    chk("stall_1", 1, stc[1], 32'd1);
    cyc();
    chk("stall_2", 1, stc[1], 32'd2);

    // Writeback g21: no bypass, ready only next cycle.
    wb(0, 1'b0, 5'd21);
    settle();
    chk("wb_no_bypass", 1, 32'(rdy[1]), 32'd0);
    cyc();
    wb_valid = '0;
    settle();
    chk("wb_ready", 1, 32'(rdy[1]), 32'd1);
    chk("wb_busy", 1, 32'(bsy[1]), 32'd0);
    chk("stall_3", 1, stc[1], 32'd3);
    cyc();
    idle();

    // WAW on f24 for both stall modes.
    dest(1'b0, 1'b1, 5'd24);
    cyc();
    settle();
    chk("waw1_stall", 1, 32'(rdy[1]), 32'd0);
    chk("waw0_ok", 0, 32'(rdy[0]), 32'd1);
    cyc();
    settle();
    chk("waw0_cnt2_ok", 0, 32'(rdy[0]), 32'd1);
    cyc();
    settle();
    chk("waw0_sat_stall", 0, 32'(rdy[0]), 32'd0);
    cyc();
    chk("waw_stall1", 1, stc[1], 32'd6);
    chk("waw_stall0", 0, stc[0], 32'd4);
    idle();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    settle();
    chk("flush_busy", 1, 32'(bsy[1]), 32'd0);
    chk("flush_busy", 0, 32'(bsy[0]), 32'd0);

    // g0 is never tracked.
    dest(1'b1, 1'b0, 5'd0);
    cyc();
    idle();
    settle();
    chk("g0_busy", 1, 32'(bsy[1]), 32'd0);
    dest(1'b1, 1'b0, 5'd0);
    src(0, 1'b0, 5'd0);
    settle();
    chk("g0_ready", 1, 32'(rdy[1]), 32'd1);
    cyc();
    idle();
    wb(0, 1'b0, 5'd0);
    wb(1, 1'b0, 5'd0);
    cyc();
    idle();
    settle();
    chk("g0_uf", 1, 32'(ufe[1]), 32'd0);

    // g5: accept plus double writeback, then double writeback underflow.
    dest(1'b1, 1'b0, 5'd5);
    cyc();
    cyc();
    wb(0, 1'b0, 5'd5);
    wb(1, 1'b0, 5'd5);
    settle();
    chk("g5_accept", 0, 32'(rdy[0]), 32'd1);
    cyc();
    idle();
    settle();
    chk("g5_model", 0, 32'(m_cnt[0][0][5]), 32'd1);
    chk("g5_busy", 0, 32'(bsy[0]), 32'd1);
    chk("g5_no_uf", 0, 32'(ufe[0]), 32'd0);
    chk("g5_uf_waw1", 1, 32'(ufe[1]), 32'd1);
    wb(0, 1'b0, 5'd5);
    wb(1, 1'b0, 5'd5);
    cyc();
    idle();
    settle();
    chk("g5_uf", 0, 32'(ufe[0]), 32'd1);
    chk("g5_idle", 0, 32'(bsy[0]), 32'd0);
    chk("g5_model0", 0, 32'(m_cnt[0][0][5]), 32'd0);

    // Flush with pending g6/f7 and a same-cycle accept to g8.
    dest(1'b1, 1'b0, 5'd6);
    cyc();
    dest(1'b0, 1'b1, 5'd7);
    cyc();
    dest(1'b1, 1'b0, 5'd8);
    flush = 1'b1;
    cyc();
    idle();
    settle();
    chk("flush2_busy", 1, 32'(bsy[1]), 32'd0);
    chk("flush2_busy", 0, 32'(bsy[0]), 32'd0);
    src(0, 1'b0, 5'd8);
    src(1, 1'b1, 5'd7);
    src(2, 1'b0, 5'd6);
    settle();
    chk("flush2_ready", 1, 32'(rdy[1]), 32'd1);
    cyc();
    idle();

    // Asynchronous reset in the middle of a stall.
    dest(1'b1, 1'b0, 5'd9);
    cyc();
    idle();
    src(2, 1'b0, 5'd9);
    cyc();
    cyc();
    rst_n = 1'b0;
    settle();
    chk("rst_mid_stall", 1, stc[1], 32'd0);
    chk("rst_mid_busy", 1, 32'(bsy[1]), 32'd0);
    chk("rst_mid_uf", 1, 32'(ufe[1]), 32'd0);
    chk("rst_mid_ready", 1, 32'(rdy[1]), 32'd1);
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;

    // Random traffic on a small register window to provoke hazards.
    for (int k = 0; k < 3000; k++) begin
      issue_valid       = ($urandom_range(0, 3) != 0);
      issue_src_used    = 3'($urandom);
      issue_src_float   = 3'($urandom);
      for (int i = 0; i < 3; i++) issue_src_num[i] = 5'($urandom_range(0, 7));
      issue_out_general = 1'($urandom);
      issue_out_float   = 1'($urandom);
      issue_out_reg_num = 5'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++) begin
        wb_valid[p] = ($urandom_range(0, 3) == 0);
        wb_float[p] = 1'($urandom);
        wb_num[p]   = 5'($urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 40) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1'b1;
    idle();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
